cache_miss_controller: RTL and testbench

- Sequencing stage directly downstream of the 4-way tag comparator (hit/miss logic) in the set-associative cache.
- Accepts one CPU lookup at a time and samples the comparator's hit result.
- On a hit: updates the tree pseudo-LRU state and responds.
- On a miss: picks a victim way, runs a burst refill from memory into the data array, writes the new tag and valid bit, then responds.

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/cache_miss_controller_plru_array.sv | 38 +++
 rtl/cache_miss_controller.sv | 165 ++++++++++++++++
 tb/tb_cache_miss_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the cache miss controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        UPDATE,
        RESP
    } state_e;

    typedef logic [1:0] way_t;
    typedef logic [2:0] plru_t;

    localparam int NUM_WAYS = 4;

    // b0 picks the pair (0 = ways 0/1, 1 = ways 2/3); b1 or b2 picks inside the pair.
    function automatic way_t plru_victim(input plru_t plru);
        way_t way;
        if (!plru[0]) begin
            way = plru[1] ? 2'd1 : 2'd0;
        end else begin
            way = plru[2] ? 2'd3 : 2'd2;
        end
        return way;
    endfunction

    function automatic plru_t plru_update(input plru_t plru, input way_t way);
        plru_t next;
        next = plru;
        case (way)
            2'd0: begin next[0] = 1'b1; next[1] = 1'b1; end
            2'd1: begin next[0] = 1'b1; next[1] = 1'b0; end
            2'd2: begin next[0] = 1'b0; next[2] = 1'b1; end
            2'd3: begin next[0] = 1'b0; next[2] = 1'b0; end
            default: next = plru;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/cache_miss_controller_plru_array.sv
// Per-set pseudo-LRU state: one combinational read port, one synchronous write port.
module plru_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] raddr,
    output plru_t              rdata,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  plru_t              wdata
);

    localparam int DEPTH = 1 << INDEX_W;

    plru_t mem_q [DEPTH];
    plru_t mem_d [DEPTH];

    assign rdata = mem_q[raddr];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences a single cache lookup: PLRU touch on hit, victim select and burst refill on miss.
module cache_miss_controller
    import cache_pkg::*;
#(
    parameter int TAG_W   = 36,
    parameter int INDEX_W = 8,
    parameter int WORDS   = 4,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = TAG_W + INDEX_W + $clog2(WORDS * WORD_W / 8)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [INDEX_W-1:0]       req_index,
    output logic [TAG_W-1:0]         lk_tag,
    output logic [INDEX_W-1:0]       lk_index,
    input  logic                     hit,
    input  logic [1:0]               hit_way,
    input  logic [3:0]               valid_bits,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_rdata_valid,
    input  logic [WORD_W-1:0]        mem_rdata,
    output logic                     fill_we,
    output logic [1:0]               fill_way,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic [WORD_W-1:0]        fill_data,
    output logic                     tag_we,
    output logic [1:0]               tag_way,
    output logic                     resp_valid,
    output logic                     resp_hit
);

    localparam int OFF_W = ADDR_W - TAG_W - INDEX_W;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     lk_tag_q, lk_tag_d;
    logic [INDEX_W-1:0]   lk_index_q, lk_index_d;
    way_t                 victim_q, victim_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 resp_hit_q, resp_hit_d;

    plru_t                plru_rdata;
    plru_t                plru_wdata;
    logic                 plru_we;
    way_t                 miss_victim;

    plru_array #(
        .INDEX_W (INDEX_W)
    ) u_plru (
        .clk   (clk),
        .reset (reset),
        .raddr (lk_index_q),
        .rdata (plru_rdata),
        .we    (plru_we),
        .waddr (lk_index_q),
        .wdata (plru_wdata)
    );

    // An empty way always wins over the PLRU choice; lowest index first.
    always_comb begin
        miss_victim = plru_victim(plru_rdata);
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                miss_victim = way_t'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lk_tag_d   = lk_tag_q;
        lk_index_d = lk_index_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        resp_hit_d = resp_hit_q;
        plru_we    = 1'b0;
        plru_wdata = plru_rdata;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lk_tag_d   = req_tag;
                    lk_index_d = req_index;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    plru_we    = 1'b1;
                    plru_wdata = plru_update(plru_rdata, hit_way);
                    resp_hit_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    victim_d   = miss_victim;
                    resp_hit_d = 1'b0;
                    state_d    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_rdata_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                plru_we    = 1'b1;
                plru_wdata = plru_update(plru_rdata, victim_q);
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lk_tag_q   <= '0;
            lk_index_q <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            resp_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lk_tag_q   <= lk_tag_d;
            lk_index_q <= lk_index_d;
            victim_q   <= victim_d;
            cnt_q      <= cnt_d;
            resp_hit_q <= resp_hit_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign lk_tag        = lk_tag_q;
    assign lk_index      = lk_index_q;
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_addr      = {lk_tag_q, lk_index_q, {OFF_W{1'b0}}};
    assign fill_we       = (state_q == REFILL) && mem_rdata_valid;
    assign fill_way      = victim_q;
    assign fill_word     = cnt_q;
    assign fill_data     = mem_rdata;
    assign tag_we        = (state_q == UPDATE);
    assign tag_way       = victim_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_hit      = resp_hit_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed, table-driven bench for cache_miss_controller with hand-written corner sequences.
module tb_cache_miss_controller;

    localparam int TAG_W   = 36;
    localparam int INDEX_W = 8;
    localparam int WORDS   = 4;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 48;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    lk_tag;
    logic [INDEX_W-1:0]  lk_index;
    logic                hit;
    logic [1:0]          hit_way;
    logic [3:0]          valid_bits;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rdata_valid;
    logic [WORD_W-1:0]   mem_rdata;
    logic                fill_we;
    logic [1:0]          fill_way;
    logic [1:0]          fill_word;
    logic [WORD_W-1:0]   fill_data;
    logic                tag_we;
    logic [1:0]          tag_way;
    logic                resp_valid;
    logic                resp_hit;

    int n_checks = 0;
    int n_fail   = 0;
    int fill_cnt = 0;
    int tag_cnt  = 0;

    typedef struct {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] idx;
        logic               hit;
        logic [1:0]         hit_way;
        logic [3:0]         vbits;
        logic [1:0]         exp_way;
        int                 stall;
        int                 gap;
        logic [WORD_W-1:0]  data_base;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    cache_miss_controller #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .WORDS   (WORDS),
        .WORD_W  (WORD_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_tag         (req_tag),
        .req_index       (req_index),
        .lk_tag          (lk_tag),
        .lk_index        (lk_index),
        .hit             (hit),
        .hit_way         (hit_way),
        .valid_bits      (valid_bits),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .fill_we         (fill_we),
        .fill_way        (fill_way),
        .fill_word       (fill_word),
        .fill_data       (fill_data),
        .tag_we          (tag_we),
        .tag_way         (tag_way),
        .resp_valid      (resp_valid),
        .resp_hit        (resp_hit)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (fill_we) fill_cnt++;
        if (tag_we)  tag_cnt++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        checkOutput("req_ready before request", req_ready, 1);
        req_valid = 1'b1;
        req_tag   = tag;
        req_index = idx;
        step();
        req_valid = 1'b0;
        checkOutput("lk_tag latched", lk_tag, tag);
        checkOutput("lk_index latched", lk_index, idx);
        checkOutput("req_ready busy in LOOKUP", req_ready, 0);
    endtask

    task automatic do_lookup(input logic h, input logic [1:0] way, input logic [3:0] vb,
                             input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx);
        hit        = h;
        hit_way    = way;
        valid_bits = vb;
        step();
        hit        = 1'b0;
        if (h) begin
            checkOutput("hit resp_valid 2 cycles after accept", resp_valid, 1);
            checkOutput("hit resp_hit", resp_hit, 1);
            step();
            checkOutput("resp_valid single pulse", resp_valid, 0);
            checkOutput("req_ready back in IDLE", req_ready, 1);
        end else begin
            checkOutput("mem_req_valid after miss", mem_req_valid, 1);
            checkOutput("mem_addr", mem_addr, {tag, idx, 4'h0});
        end
    endtask

    task automatic grant(input int stall, input logic [ADDR_W-1:0] exp_addr);
        repeat (stall) begin
            step();
            checkOutput("mem_req_valid held while stalled", mem_req_valid, 1);
            checkOutput("mem_addr stable while stalled", mem_addr, exp_addr);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        checkOutput("mem_req_valid dropped in REFILL", mem_req_valid, 0);
    endtask

    task automatic beat(input logic [WORD_W-1:0] data, input int gap,
                        input logic [1:0] word, input logic [1:0] way);
        repeat (gap) begin
            mem_rdata_valid = 1'b0;
            #2;
            checkOutput("fill_we low in beat gap", fill_we, 0);
            step();
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = data;
        #2;
        checkOutput("fill_we with beat", fill_we, 1);
        checkOutput("fill_word", fill_word, word);
        checkOutput("fill_data", fill_data, data);
        checkOutput("fill_way is victim", fill_way, way);
        step();
        mem_rdata_valid = 1'b0;
    endtask

    task automatic finish_miss(input logic [1:0] way);
        checkOutput("tag_we after last beat", tag_we, 1);
        checkOutput("tag_way is victim", tag_way, way);
        checkOutput("no resp during UPDATE", resp_valid, 0);
        step();
        checkOutput("miss resp_valid", resp_valid, 1);
        checkOutput("miss resp_hit", resp_hit, 0);
        checkOutput("tag_we single pulse", tag_we, 0);
        step();
        checkOutput("resp_valid single pulse", resp_valid, 0);
        checkOutput("req_ready back in IDLE", req_ready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int f0, t0;
        f0 = fill_cnt;
        t0 = tag_cnt;
        send_req(v.tag, v.idx);
        do_lookup(v.hit, v.hit_way, v.vbits, v.tag, v.idx);
        if (!v.hit) begin
            grant(v.stall, {v.tag, v.idx, 4'h0});
            for (int w = 0; w < WORDS; w++) begin
                beat(v.data_base + WORD_W'(w), v.gap, 2'(w), v.exp_way);
            end
            finish_miss(v.exp_way);
            checkOutput("fill_we pulses per miss", fill_cnt - f0, WORDS);
            checkOutput("tag_we pulses per miss", tag_cnt - t0, 1);
        end
    endtask

    initial begin
        int f0, t0;

        // tag, idx, hit, hit_way, vbits, exp_way, stall, gap, data_base
        vecs[0] = '{36'h000000400, 8'd5, 1'b1, 2'd2, 4'b1111, 2'd0, 0, 0, 32'h0};
        vecs[1] = '{36'h123456789, 8'd9, 1'b0, 2'd3, 4'b1011, 2'd2, 0, 0, 32'hA0};
        vecs[2] = '{36'h0000000A1, 8'd7, 1'b0, 2'd3, 4'b1111, 2'd0, 0, 0, 32'h10};
        vecs[3] = '{36'h0000000A2, 8'd7, 1'b0, 2'd3, 4'b1111, 2'd2, 1, 0, 32'h20};
        vecs[4] = '{36'h0000000A3, 8'd7, 1'b0, 2'd3, 4'b1111, 2'd1, 0, 2, 32'h30};
        vecs[5] = '{36'h0000000A4, 8'd7, 1'b0, 2'd3, 4'b1111, 2'd3, 0, 0, 32'h40};
        vecs[6] = '{36'hABCDE0001, 8'd5, 1'b1, 2'd0, 4'b1111, 2'd0, 0, 0, 32'h0};
        vecs[7] = '{36'hABCDE0002, 8'd5, 1'b0, 2'd1, 4'b1111, 2'd3, 0, 0, 32'h50};
        vecs[8] = '{36'hFEDCBA987, 8'd3, 1'b0, 2'd0, 4'b0111, 2'd3, 5, 1, 32'h100};
        vecs[9] = '{36'h00000FFFF, 8'd3, 1'b0, 2'd0, 4'b1110, 2'd0, 0, 0, 32'h200};

        reset           = 1'b1;
        req_valid       = 1'b0;
        req_tag         = '0;
        req_index       = '0;
        hit             = 1'b0;
        hit_way         = '0;
        valid_bits      = '0;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset mem_req_valid", mem_req_valid, 0);
        checkOutput("reset fill_we", fill_we, 0);
        checkOutput("reset tag_we", tag_we, 0);
        checkOutput("reset resp_valid", resp_valid, 0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
        end

        // Set 5 PLRU is now 3'b010, so an all-valid miss picks way 1; reset abandons it.
        $display("[TB] reset during refill");
        t0 = tag_cnt;
        send_req(36'h055550000, 8'd5);
        do_lookup(1'b0, 2'd0, 4'b1111, 36'h055550000, 8'd5);
        grant(0, {36'h055550000, 8'd5, 4'h0});
        beat(32'hC0, 0, 2'd0, 2'd1);
        beat(32'hC1, 0, 2'd1, 2'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("post-reset req_ready", req_ready, 1);
        checkOutput("post-reset tag_we", tag_we, 0);
        checkOutput("post-reset mem_req_valid", mem_req_valid, 0);
        checkOutput("post-reset resp_valid", resp_valid, 0);
        step();
        step();
        checkOutput("abandoned refill issued no tag_we", tag_cnt - t0, 0);
        f0 = fill_cnt;
        t0 = tag_cnt;
        send_req(36'h055550001, 8'd5);
        do_lookup(1'b0, 2'd0, 4'b1111, 36'h055550001, 8'd5);
        grant(0, {36'h055550001, 8'd5, 4'h0});
        for (int w = 0; w < WORDS; w++) begin
            beat(32'hD0 + WORD_W'(w), 0, 2'(w), 2'd0);
        end
        finish_miss(2'd0);
        checkOutput("fill pulses after reset", fill_cnt - f0, WORDS);
        checkOutput("tag pulses after reset", tag_cnt - t0, 1);

        // A request held high through a miss is taken on the first IDLE cycle.
        $display("[TB] held request during miss");
        send_req(36'h111111111, 8'd20);
        req_valid = 1'b1;
        req_tag   = 36'h222222222;
        req_index = 8'd21;
        hit        = 1'b0;
        valid_bits = 4'b0000;
        step();
        checkOutput("held req: req_ready low in MISS_REQ", req_ready, 0);
        checkOutput("held req: mem_addr keeps first tag", mem_addr, {36'h111111111, 8'd20, 4'h0});
        grant(1, {36'h111111111, 8'd20, 4'h0});
        checkOutput("held req: req_ready low in REFILL", req_ready, 0);
        for (int w = 0; w < WORDS; w++) begin
            beat(32'hE0 + WORD_W'(w), 0, 2'(w), 2'd0);
        end
        checkOutput("held req: req_ready low in UPDATE", req_ready, 0);
        finish_miss(2'd0);
        step();
        req_valid = 1'b0;
        checkOutput("held req: accepted tag", lk_tag, 36'h222222222);
        checkOutput("held req: accepted index", lk_index, 8'd21);
        checkOutput("held req: busy after accept", req_ready, 0);
        do_lookup(1'b1, 2'd1, 4'b1111, 36'h222222222, 8'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
